// File: rtl/par_chk.sv
// par_chk: AR/ARX odd-parity checker with sticky flags, saturating error count, first-error capture and CON request handshake
module par_chk (
    input  logic        clk,
    input  logic        CROBAR,
    input  logic [0:35] ar,
    input  logic        ar_36,
    input  logic        ar_load,
    input  logic [0:35] arx,
    input  logic        arx_36,
    input  logic        arx_load,
    input  logic        chk_en,
    input  logic        clr,
    input  logic        ack,
    output logic        ar_par_err,
    output logic        arx_par_err,
    output logic [7:0]  err_cnt,
    output logic [36:0] cap_word,
    output logic        cap_arx,
    output logic        cap_valid,
    output logic        par_req
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;
    state_t state, state_nxt;
    logic ar_v, arx_v, ar_xl, ar_xr, arx_xl, arx_xr;
    logic [36:0] ar_w, arx_w;
    logic ar_err, arx_err, any_err, pend, pend_nxt;
    logic [8:0] cnt_sum;

    // Split XOR halves keep the parity tree short ahead of the stage-1 compare
    always_ff @(posedge clk or posedge CROBAR)
        if (CROBAR) begin
            ar_v   <= 1'b0;
            arx_v  <= 1'b0;
            ar_xl  <= 1'b0;
            ar_xr  <= 1'b0;
            arx_xl <= 1'b0;
            arx_xr <= 1'b0;
            ar_w   <= '0;
            arx_w  <= '0;
        end else begin
            ar_v   <= ar_load & chk_en;
            arx_v  <= arx_load & chk_en;
            ar_xl  <= ^ar[0:17];
            ar_xr  <= ^{ar[18:35], ar_36};
            arx_xl <= ^arx[0:17];
            arx_xr <= ^{arx[18:35], arx_36};
            ar_w   <= {ar, ar_36};
            arx_w  <= {arx, arx_36};
        end

    assign ar_err  = ar_v & ~(ar_xl ^ ar_xr);
    assign arx_err = arx_v & ~(arx_xl ^ arx_xr);
    assign any_err = ar_err | arx_err;
    assign cnt_sum = {1'b0, clr ? 8'd0 : err_cnt} + {8'd0, ar_err} + {8'd0, arx_err};
    assign par_req = state == REQ;

    // A new error always wins over a coincident clr
    always_ff @(posedge clk or posedge CROBAR)
        if (CROBAR) begin
            ar_par_err  <= 1'b0;
            arx_par_err <= 1'b0;
            err_cnt     <= '0;
            cap_word    <= '0;
            cap_arx     <= 1'b0;
            cap_valid   <= 1'b0;
            pend        <= 1'b0;
            state       <= IDLE;
        end else begin
            ar_par_err  <= ar_err | (ar_par_err & ~clr);
            arx_par_err <= arx_err | (arx_par_err & ~clr);
            err_cnt     <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
            cap_valid   <= any_err | (cap_valid & ~clr);
            if (any_err && (clr || !cap_valid)) begin
                cap_word <= ar_err ? ar_w : arx_w;
                cap_arx  <= ~ar_err;
            end
            pend  <= pend_nxt;
            state <= state_nxt;
        end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend & ~clr;
        if (state == IDLE) begin
            state_nxt = (any_err || pend) ? REQ : IDLE;
            pend_nxt  = 1'b0;
        end else begin
            pend_nxt  = any_err | pend_nxt;
            state_nxt = (state == REQ && ack) ? WAIT_REL : (state == WAIT_REL && !ack) ? IDLE : state;
        end
    end
endmodule

// File: doc/par_chk.md
# par_chk

AR/ARX parity checker: receiving end of the odd-parity scheme whose generator produces `AR_PAR_ODD`/`ARX_PAR_ODD` beside the shift matrix. It checks every word loaded into AR or ARX against its stored bit 36, latches sticky per-register error flags, and counts errors in a saturating counter. It captures the first failing word and raises a request/acknowledge interrupt to CON. It sits between the EDP register load path and CON's error and interrupt logic.

## Interface

- No parameters; all widths are fixed by the KL10 word.
- `clk`  in  1  EBOX clock; all state changes on its rising edge.
- `CROBAR`  in  1  Reset. Asynchronous, active-high.
- `ar`  in  36  AR data [0:35], sampled when `ar_load`=1.
- `ar_36`  in  1  Stored parity bit for `ar`.
- `ar_load`  in  1  AR word valid this cycle.
- `arx`  in  36  ARX data [0:35], sampled when `arx_load`=1.
- `arx_36`  in  1  Stored parity bit for `arx`.
- `arx_load`  in  1  ARX word valid this cycle.
- `chk_en`  in  1  Enables checking. Sampled with the load strobe in stage 0.
- `clr`  in  1  Synchronous clear of flags, counter, capture, and pending.
- `ack`  in  1  CON acknowledge of `par_req`.
- `ar_par_err`  out  1  Sticky AR parity error.
- `arx_par_err`  out  1  Sticky ARX parity error.
- `err_cnt`  out  8  Saturating count of failing words.
- `cap_word`  out  37  First failing word, {data[0:35], bit36}.
- `cap_arx`  out  1  1 = the captured word came from ARX, 0 = from AR.
- `cap_valid`  out  1  `cap_word` holds a valid capture.
- `par_req`  out  1  Interrupt request to CON.

## Operation

- **Parity rule:** a word is good when the XOR of its 36 data bits and bit 36 equals 1 (odd parity). An XOR result of 0 is an error.
- **Stage 0 (load edge):**
  - For each channel, register `load & chk_en` as a valid bit.
  - Register the XOR of bits [0:17], the XOR of {bits [18:35], bit36}, and the full 37-bit word.
  - When `chk_en`=0, the word is ignored entirely.
- **Stage 1:**
  - err = valid & ~(xorL ^ xorR) for each channel.
  - On err, set the channel's sticky flag.
  - Increment `err_cnt` by the number of failing channels (0, 1 or 2), saturating at 255. At 254 with two errors the result is 255.
- **Capture:**
  - When `cap_valid`=0 and any stage-1 error occurs, load `cap_word` and `cap_arx` and set `cap_valid`.
  - If AR and ARX fail in the same cycle, AR is captured (`cap_arx`=0).
  - Capture stays frozen until `clr`.
- **Request FSM, states IDLE, REQ, WAIT_REL:**
  - IDLE → REQ when there is a stage-1 error or `pend`=1; `pend` is cleared on entering REQ.
  - REQ: `par_req`=1. REQ → WAIT_REL when `ack`=1.
  - WAIT_REL: `par_req`=0. WAIT_REL → IDLE when `ack`=0.
  - A stage-1 error while in REQ or WAIT_REL sets `pend`. It is still flagged and counted but does not extend the current request.
  - `ack` while in IDLE is ignored.
- **`clr`:**
  - Clears both flags, `err_cnt`, `cap_valid`, and `pend`. `cap_word` data is don't-care once `cap_valid`=0.
  - Does not alter FSM state or the pipeline.
  - If `clr` coincides with a stage-1 error, the error wins: flag=1, `err_cnt` = number of failing channels that cycle, capture loaded, `pend` or REQ handled per the normal rules.
- **Reset (`CROBAR`=1, at any time):**
  - All outputs are 0, `cap_word`=0, FSM=IDLE, pipeline valid bits=0, `pend`=0.
  - A word in flight at reset is discarded and never flagged.

## Timing

- Load at edge N (stage 0) produces stage-1 evaluation at edge N+1.
  - Flags, `err_cnt`, and capture are visible in the cycle after edge N+1, i.e. 2 cycles after the load cycle.
  - `par_req` rises in that same cycle if the FSM was in IDLE.
- Back-to-back loads every cycle are fully pipelined with no stalls.
- `par_req` falls the cycle after `ack` is sampled high.
- Minimum handshake is 3 cycles: REQ, WAIT_REL, then IDLE with `ack` low. A pending error re-raises `par_req` the cycle after IDLE is entered.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Test plan

- **Good word:** `ar`=36'o000000000001, `ar_36`=0, `ar_load`=1, `chk_en`=1 → XOR=1, no flag, `err_cnt`=0, `par_req` stays 0.
- **Bad ARX word:** `arx`=36'o777777777777, `arx_36`=0 → two cycles later `arx_par_err`=1, `err_cnt`=1, `cap_word`={36'o777777777777,0}, `cap_arx`=1, `par_req`=1. Then `ack`=1 → `par_req`=0 next cycle; `ack`=0 → IDLE.
- **Simultaneous errors:** AR and ARX both bad in one cycle → both flags set, `err_cnt`=2, `cap_arx`=0. A second error during REQ → `pend`=1 and `par_req` re-raises after the handshake completes.
- **Saturation, clr priority, chk_en:** 300 bad AR loads → `err_cnt`=255. `clr` coincident with a stage-1 error → `err_cnt`=1 and `ar_par_err`=1. With `chk_en`=0 a bad word produces no flag.
- **Reset mid-flight:** assert `CROBAR` asynchronously one cycle after a bad load → every output is 0 immediately, and after release no flag or request appears for the discarded word.
